// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_pkg
// Description : Shared types, widths and the 16-bit saturation helper for the
//               dot-product sequencer that drives the signed 8-bit MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_pkg;

  localparam int ACC_W = 26;
  localparam int OP_W  = 8;
  localparam int SAT_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd32768;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Clamp a full accumulator value into the signed 16-bit range.
  function automatic logic signed [SAT_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [SAT_W-1:0] r;
    if (acc > SAT_MAX) begin
      r = SAT_W'(SAT_MAX);
    end else if (acc < SAT_MIN) begin
      r = SAT_W'(SAT_MIN);
    end else begin
      r = acc[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_seq_if
// Description : Command, operand stream, MAC drive and result port bundle of
//               the dot-product sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_seq_if
  import dot_pkg::*;
#(
  parameter int LEN_W = 8
);

  // Job control
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    abort;
  logic                    busy;

  // Operand stream
  logic                    op_vld;
  logic signed [OP_W-1:0]  op_a;
  logic signed [OP_W-1:0]  op_b;
  logic                    op_rdy;

  // MAC drive and readback
  logic signed [OP_W-1:0]  mac_in1;
  logic signed [OP_W-1:0]  mac_in2;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] mac_acc;

  // Result port
  logic                    res_vld;
  logic                    res_rdy;
  logic signed [ACC_W-1:0] res;
  logic signed [SAT_W-1:0] res_sat;

  // Sequencer side
  modport slave (
    input  start, len, abort, op_vld, op_a, op_b, mac_acc, res_rdy,
    output busy, op_rdy, mac_in1, mac_in2, mac_clr, res_vld, res, res_sat
  );

  // Environment side
  modport master (
    output start, len, abort, op_vld, op_a, op_b, mac_acc, res_rdy,
    input  busy, op_rdy, mac_in1, mac_in2, mac_clr, res_vld, res, res_sat
  );

endinterface
`default_nettype wire

// File: rtl/dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : dot_seq
// Description : Sequencer in front of the signed 8-bit MAC. Accepts a start
//               with a vector length, gates that many operand pairs into the
//               MAC, captures the accumulator and offers full and saturated
//               results on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_seq
  import dot_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  dot_seq_if.slave   bus
);

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        r_len;
  logic                    w_op_rdy;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_busy;
  logic                    w_clr;
  logic                    r_res_vld;
  logic signed [ACC_W-1:0] r_res;
  logic signed [SAT_W-1:0] r_res_sat;

  // Ready only while pairs remain; abort suppresses the handshake outright so
  // no product can sneak into the MAC in the abort cycle.
  assign w_op_rdy = (r_state == RUN) && (r_cnt < r_len) && !bus.abort;
  assign w_hs     = bus.op_vld && w_op_rdy;
  assign w_last   = (r_cnt == (r_len - LEN_W'(1)));

  // State, pair counter and latched length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && bus.start && (bus.len != '0)) begin
        r_len <= bus.len;
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  // Next-state decode plus busy and MAC clear.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        w_clr  = 1'b1;
        if (bus.start) begin
          // A zero-length job skips RUN; the cleared MAC already reads 0.
          w_next = (bus.len != '0) ? RUN : CAPTURE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_hs && w_last) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next = bus.abort ? IDLE : DONE;
      end
      DONE: begin
        w_clr = 1'b1;
        if (bus.res_rdy) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Result register: loaded in CAPTURE, valid dropped once consumed in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_vld <= 1'b0;
      r_res     <= '0;
      r_res_sat <= '0;
    end else if ((r_state == CAPTURE) && !bus.abort) begin
      r_res_vld <= 1'b1;
      r_res     <= bus.mac_acc;
      r_res_sat <= sat16(bus.mac_acc);
    end else if ((r_state == DONE) && bus.res_rdy) begin
      r_res_vld <= 1'b0;
    end
  end

  // The MAC adds every cycle, so operands are zero unless a pair is accepted.
  assign bus.mac_in1 = w_hs ? bus.op_a : '0;
  assign bus.mac_in2 = w_hs ? bus.op_b : '0;
  assign bus.mac_clr = w_clr;
  assign bus.op_rdy  = w_op_rdy;
  assign bus.busy    = w_busy;
  assign bus.res_vld = r_res_vld;
  assign bus.res     = r_res;
  assign bus.res_sat = r_res_sat;

endmodule
`default_nettype wire
